multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle control sequencer for the RV32I-subset core. It steps each instruction through fetch, decode, execute, memory and writeback over several cycles. It drives the instruction register, PC, immediate generator select, ALU, register file and a shared instruction/data memory port with a req/ready handshake. Branch offsets come from the immediate generator in SB mode, and this block alone decides when the PC takes them.

## Interface
- MEM_TIMEOUT, 255: max cycles mem_req may wait for mem_ready before a timeout trap (1..65535).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- instr  in  32  memory read data; sampled as the instruction in FETCH on the mem_ready cycle.
- mem_ready  in  1  memory completes the current request this cycle.
- alu_zero  in  1  ALU result == 0, valid in EXEC.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  request is a store.
- ir_we  out  1  latch instr into the instruction register.
- pc_we  out  1  update PC this cycle.
- pc_src  out  2  0 = PC+4, 1 = PC+imm (branch), 2 = PC+imm (jump).
- imm_sel  out  2  0 = I, 1 = S, 2 = SB, 3 = UJ.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- alu_op  out  2  0 = add, 1 = sub, 2 = funct-decoded.
- reg_we  out  1  register-file write.
- mem_to_reg  out  1  writeback selects memory data.
- busy  out  1  state != FETCH.
- trap  out  1  sticky; controller halted.
- trap_cause  out  2  0 = none, 1 = illegal instruction, 2 = memory timeout.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are a Moore decode of the state plus the registered opcode and funct3.
- Strobes (ir_we, pc_we, reg_we, mem_req, mem_we) are 0 in any state unless listed below.
- FETCH: mem_req=1, mem_we=0. On mem_ready: ir_we=1, go to DECODE.
- DECODE: classify the opcode.
  - Legal: 0110011 R, 0010011 I-ALU, 0000011 load, 0100011 store.
  - 1100011 branch is legal only with funct3 000 (beq) or 001 (bne).
  - Anything else goes to TRAP with cause 1.
- EXEC:
  - R: alu_src_b=0, alu_op=2.
  - I-ALU and load: imm_sel=0, alu_src_b=1, alu_op=0.
  - Store: imm_sel=1, alu_src_b=1, alu_op=0.
  - Branch: imm_sel=2, alu_src_b=0, alu_op=1, pc_we=1. pc_src=1 if taken, else 0, where taken = alu_zero XOR funct3[0]. Then go to FETCH.
  - R and I-ALU go to WB; load and store go to MEM.
- MEM: mem_req=1, mem_we=store. On mem_ready: a load goes to WB; a store sets pc_we=1, pc_src=0 and goes to FETCH.
- WB: reg_we=1, mem_to_reg=load, pc_we=1, pc_src=0, then go to FETCH.
- Timeout counter:
  - Clears on entry to FETCH and MEM and whenever mem_ready=1.
  - Increments on each cycle with mem_req=1 and mem_ready=0.
  - Reaching MEM_TIMEOUT goes to TRAP with cause 2; mem_req drops that cycle.
- TRAP: all strobes 0, trap=1, trap_cause held. Only reset exits TRAP.

## Timing
- Reset values: every strobe 0, pc_src=0, imm_sel=0, alu_src_b=0, alu_op=0, mem_to_reg=0, busy=0, trap=0, trap_cause=0, timeout counter 0. While rst_n=0, mem_req is forced to 0.
- The first edge with rst_n=1 enters FETCH, so mem_req=1 in the following cycle.
- Minimum cycles with mem_ready immediate: branch 3, R/I-ALU 4, store 4, load 5.
- Each mem_ready cycle adds one cycle of latency.
- mem_req and mem_we stay stable from assertion until the mem_ready cycle.
- mem_ready arriving while mem_req=0 is ignored.
- mem_ready arriving in the same cycle the counter hits MEM_TIMEOUT: mem_ready wins and there is no trap.
- Reset asserted mid-instruction: next edge gives reset values, abandons the access and clears trap.
- Exactly one pc_we pulse per retired instruction; none for a trapped instruction.

## Configuration
- MULTICYCLE_JAL_EN defined:
  - Opcode 1101111 (JAL) is legal.
  - EXEC: imm_sel=3, pc_we=1, pc_src=2, then WB.
  - WB: reg_we=1, mem_to_reg=0, no pc_we. The datapath writes PC+4, latched before the PC update.
  - Latency 4 cycles.
- MULTICYCLE_JAL_EN undefined: opcode 1101111 traps with cause 1, and imm_sel never takes value 3.

## Structure
- Package ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - imm_sel, pc_src, alu_op and trap_cause encodings.
- The immediate generator and ALU decoder share the imm_sel and alu_op codes from ctrl_pkg.
- Sub-module ctrl_decode: combinational classifier, opcode/funct3 -> instruction class + legal flag. Instantiated once; its outputs are registered at the DECODE edge.

## Test plan
- Reset, then add x1,x2,x3 (0x003100B3) with mem_ready on the first request cycle -> states FETCH, DECODE, EXEC, WB; reg_we=1 only in WB; exactly one pc_we with pc_src=0; busy=0 on cycle 5.
- beq with alu_zero=1 -> pc_we, pc_src=1 and imm_sel=2 in EXEC (cycle 3). Same with alu_zero=0 -> pc_src=0. bne inverts both cases.
- Load with mem_ready delayed 3 cycles in MEM -> mem_req and mem_we=0 held 4 cycles; WB has mem_to_reg=1, reg_we=1; total 8 cycles.
- MEM_TIMEOUT=4, mem_ready never asserted in FETCH -> trap=1, trap_cause=2 after 4 waiting cycles; mem_req=0 from then on. rst_n low clears trap.
- Instruction 0x0000007F, or bge (funct3 101) -> TRAP with cause 1, no pc_we, no reg_we.
- JAL (0x008000EF) with MULTICYCLE_JAL_EN -> pc_src=2 and imm_sel=3 in EXEC, reg_we in WB. Without the macro -> trap_cause=1.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer: states, opcodes, datapath select codes.
// The immediate generator and ALU decoder use the same imm_sel / alu_op codes.
package ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_FETCH  = 3'd0;
    localparam state_t S_DECODE = 3'd1;
    localparam state_t S_EXEC   = 3'd2;
    localparam state_t S_MEM    = 3'd3;
    localparam state_t S_WB     = 3'd4;
    localparam state_t S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] IMM_I  = 2'd0;
    localparam logic [1:0] IMM_S  = 2'd1;
    localparam logic [1:0] IMM_SB = 2'd2;
    localparam logic [1:0] IMM_UJ = 2'd3;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL
    } instr_class_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port: request/ready handshake plus read data.
interface multicycle_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ready;
    logic [31:0] instr;

    modport master (output mem_req, output mem_we, input mem_ready, input instr);
    modport slave  (input mem_req, input mem_we, output mem_ready, output instr);
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational opcode/funct3 classifier for the sequencer.
// MULTICYCLE_JAL_EN makes opcode 1101111 (JAL) legal.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    output instr_class_t cls,
    output logic         legal
);

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cls   = CLS_R;
        legal = 1'b0;
        case (opcode)
            OP_R:      begin cls = CLS_R;     legal = 1'b1; end
            OP_IMM:    begin cls = CLS_IMM;   legal = 1'b1; end
            OP_LOAD:   begin cls = CLS_LOAD;  legal = 1'b1; end
            OP_STORE:  begin cls = CLS_STORE; legal = 1'b1; end
            // Only beq (000) and bne (001) are implemented.
            OP_BRANCH: begin cls = CLS_BRANCH; legal = (funct3[2:1] == 2'b00); end
`ifdef MULTICYCLE_JAL_EN
            OP_JAL:    begin cls = CLS_JAL;   legal = 1'b1; end
`endif
            default:   ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control sequencer with a req/ready memory port and trap handling.
// MULTICYCLE_JAL_EN adds JAL support; without it JAL traps as an illegal instruction.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master mem,
    input  logic              alu_zero,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_src,
    output logic [1:0]        imm_sel,
    output logic              alu_src_b,
    output logic [1:0]        alu_op,
    output logic              reg_we,
    output logic              mem_to_reg,
    output logic              busy,
    output logic              trap,
    output logic [1:0]        trap_cause
);

    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    state_t       state;
    state_t       state_d;
    logic         armed;
    logic [6:0]   op_q;
    logic [2:0]   f3_q;
    instr_class_t cls_q;
    instr_class_t cls_d;
    logic         legal;
    logic [1:0]   cause_q;
    logic [15:0]  tmo_cnt;
    logic         mem_req_int;
    logic         mem_done;
    logic         timeout_hit;
    logic         is_store;
    logic         unused_instr;

    ctrl_decode u_decode (
        .opcode (op_q),
        .funct3 (f3_q),
        .cls    (cls_d),
        .legal  (legal)
    );

    assign unused_instr = ^{mem.instr[31:15], mem.instr[11:7]};
    assign is_store     = (cls_q == CLS_STORE);

    // armed keeps the port quiet until the first edge after reset has entered FETCH.
    assign mem_req_int = rst_n && armed && (state == S_FETCH || state == S_MEM);
    assign mem_done    = mem_req_int && mem.mem_ready;
    assign timeout_hit = mem_req_int && !mem.mem_ready && (tmo_cnt == TMO_LAST);

    assign mem.mem_req = mem_req_int;
    assign mem.mem_we  = mem_req_int && (state == S_MEM) && is_store;

    always_comb begin
        state_d = state;
        case (state)
            S_FETCH: begin
                if (mem_done)         state_d = S_DECODE;
                else if (timeout_hit) state_d = S_TRAP;
            end
            S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (cls_q)
                    CLS_BRANCH:          state_d = S_FETCH;
                    CLS_LOAD, CLS_STORE: state_d = S_MEM;
                    default:             state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_done)         state_d = is_store ? S_FETCH : S_WB;
                else if (timeout_hit) state_d = S_TRAP;
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            armed   <= 1'b0;
            op_q    <= '0;
            f3_q    <= '0;
            cls_q   <= CLS_R;
            cause_q <= CAUSE_NONE;
            tmo_cnt <= '0;
        end else begin
            state <= state_d;
            armed <= 1'b1;
            if (state == S_FETCH && mem_done) begin
                op_q <= mem.instr[6:0];
                f3_q <= mem.instr[14:12];
            end
            if (state == S_DECODE) cls_q <= cls_d;
            if (state_d == S_TRAP && state != S_TRAP)
                cause_q <= (state == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
            if (mem.mem_ready || (state_d != state && (state_d == S_FETCH || state_d == S_MEM)))
                tmo_cnt <= '0;
            else if (mem_req_int)
                tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    always_comb begin
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_PLUS4;
        imm_sel    = IMM_I;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        case (state)
            S_FETCH: ir_we = mem_done;
            S_EXEC: begin
                case (cls_q)
                    CLS_R: alu_op = ALU_FUNCT;
                    CLS_IMM, CLS_LOAD: alu_src_b = 1'b1;
                    CLS_STORE: begin
                        imm_sel   = IMM_S;
                        alu_src_b = 1'b1;
                    end
                    CLS_BRANCH: begin
                        imm_sel = IMM_SB;
                        alu_op  = ALU_SUB;
                        pc_we   = 1'b1;
                        pc_src  = (alu_zero ^ f3_q[0]) ? PC_BRANCH : PC_PLUS4;
                    end
`ifdef MULTICYCLE_JAL_EN
                    CLS_JAL: begin
                        imm_sel = IMM_UJ;
                        pc_we   = 1'b1;
                        pc_src  = PC_JUMP;
                    end
`endif
                    default: ;
                endcase
            end
            S_MEM: pc_we = mem_done && is_store;
            S_WB: begin
                reg_we     = 1'b1;
                mem_to_reg = (cls_q == CLS_LOAD);
                // JAL already moved the PC in EXEC; WB only writes the link value.
                pc_we      = (cls_q != CLS_JAL);
            end
            default: ;
        endcase
    end

    assign busy       = (state != S_FETCH);
    assign trap       = (state == S_TRAP);
    assign trap_cause = cause_q;

endmodule
